pci_dma_master: RTL
===================

Name: pci_dma_master

Overview:
User-side initiator engine that drives the master handshake of one PCI function core: REQUEST, M_CBE, M_WRDN, COMPLETE and M_READY. It turns a single command (address, dword length, direction) into one or more PCI memory bursts. It buffers write data so that disconnected or timed-out bursts can be replayed, and resumes after a disconnect at the first uncommitted dword. One instance sits beside each function core, on that core's P*_ master ports.

Parameters:
LEN_W, 12, width of command length in dwords.
BUF_AW, 4, log2 depth of the write replay buffer (16 dwords).
MAX_BURST, 16, maximum dwords per PCI transaction; must be ≤ 2**BUF_AW.
MAX_RETRY, 255, consecutive zero-progress attempts allowed before error.

Ports:
CLK  in  1  PCI clock.
RST_N  in  1  asynchronous active-low reset.
CMD_VALID  in  1  command request.
CMD_READY  out  1  high in IDLE.
CMD_ADDR  in  32  dword-aligned byte address; bits [1:0] are ignored.
CMD_LEN  in  LEN_W  dword count.
CMD_WRITE  in  1  1 = memory write, 0 = memory read.
WR_DATA  in  32  write stream data.
WR_VALID  in  1  write stream valid.
WR_READY  out  1  buffer not full and a write command is active with unfetched dwords.
RD_DATA  out  32  read data.
RD_VALID  out  1  one-cycle pulse per read dword; no backpressure.
BUSY  out  1  high whenever the FSM is not in IDLE.
DONE  out  1  one-cycle completion pulse.
ERROR  out  1  retry limit exceeded; held until the next command is accepted.
REQUEST  out  1  to core; one-cycle pulse.
REQUESTHOLD  out  1  tied 0.
M_CBE  out  4  to core.
M_WRDN  out  1  to core.
COMPLETE  out  1  to core.
M_READY  out  1  to core.
ADIO_IN  out  32  to core P*_ADIO_IN.
ADIO_OUT  in  32  from core P*_ADIO_OUT.
M_DATA_VLD  in  1  from core.
M_SRC_EN  in  1  from core.
M_DATA  in  1  from core.
M_ADDR_N  in  1  from core.
TIME_OUT  in  1  from core.
STOPQ_N  in  1  from core.

Behaviour:
Reset values: all outputs 0 except CMD_READY=1. All pointers and counters are cleared. Reset is asynchronous and takes effect mid-burst; there is no bus cleanup, and the core handles the abandoned transaction.

FSM states: IDLE, REQ, WAIT_ADDR, DATA, END, FIN.
- IDLE, CMD_VALID=1: latch addr, len and dir; clear committed count, retry count and ERROR.
  - len=0: go to FIN; DONE pulses on the next cycle and there is no bus activity.
  - otherwise: go to REQ.
- REQ: REQUEST=1 for exactly one cycle, then WAIT_ADDR.
- WAIT_ADDR, M_ADDR_N=0:
  - ADIO_IN = base + 4*committed.
  - M_CBE = 4'b0111 for write, 4'b0110 for read.
  - M_WRDN = dir.
  - Go to DATA.
- DATA, while M_DATA=1:
  - M_CBE = 4'b0000.
  - Write: ADIO_IN = buf[src_ptr]; src_ptr advances on M_SRC_EN (speculative).
  - Every M_DATA_VLD=1 cycle commits one dword. For write, commit_ptr advances and the entry is freed. For read, RD_DATA <= ADIO_OUT and RD_VALID pulses the following cycle.
  - M_READY: read = 1; write = (src_ptr != wr_ptr).
  - burst_left = min(MAX_BURST, len - committed) latched at address phase, decremented per commit. COMPLETE = 1 while burst_left ≤ 1 in DATA.
- DATA, M_DATA falls: go to END.
- END:
  - committed == len: go to FIN.
  - otherwise (TIME_OUT, STOPQ_N disconnect/retry, or burst cap reached): src_ptr <= commit_ptr (rewind).
  - If this attempt committed zero dwords, retry_cnt increments; if it exceeds MAX_RETRY, set ERROR=1 and go to FIN.
  - Any progress clears retry_cnt. Then return to REQ.
- FIN: DONE=1 for one cycle, go to IDLE.

Write buffer rules:
- Filled via WR handshake until total fetched == len.
- Full when wr_ptr - commit_ptr == 2**BUF_AW.
- Uses pointer width BUF_AW+1 for the full/empty distinction.
- A write and a commit in the same cycle are both honoured.

Arithmetic and constraints:
- Address arithmetic is modulo 2**32.
- 4 KB boundary crossing is the command issuer's responsibility.

Test Plan:
- Write, LEN=4, ADDR=0x1000_0000, no stop → ADIO_IN=0x1000_0000 and M_CBE=0x7 at address phase; 4 commits in order D0..D3; COMPLETE high on the 4th; one DONE pulse; ERROR=0.
- Read, LEN=8, ADDR=0x2000 → M_CBE=0x6 at address phase; 8 RD_VALID pulses with RD_DATA matching ADIO_OUT order.
- Write, LEN=10, STOPQ_N low after 3 commits with 2 extra M_SRC_EN prefetches → second REQUEST; address phase 0x200C; data resumes at D3; DONE after 10 commits.
- LEN=40, MAX_BURST=16 → three transactions at base, base+0x40, base+0x80 of 16/16/8 dwords.
- MAX_RETRY=2, target retries every attempt with zero commits → three REQUEST pulses, then ERROR=1 and DONE pulse.
- RST_N low mid-DATA → REQUEST, COMPLETE, M_READY and BUSY 0 immediately. LEN=0 command after reset → DONE after 1 cycle, REQUEST never asserted.

Source files
------------

// File: rtl/pci_dma_master_if.sv
// Bundles every non-clock signal between the DMA initiator engine, its user
// logic and the PCI function core master ports.
//   master modport : the DMA engine's view (drives REQUEST/M_CBE/... and the
//                    user-side status and read stream).
//   slave modport  : the environment's view (user command/write stream and
//                    the core's master-side status outputs).
// User side : CMD_* command handshake, WR_* write stream, RD_* read stream,
//             BUSY/DONE/ERROR status.
// Core side : REQUEST, REQUESTHOLD, M_CBE, M_WRDN, COMPLETE, M_READY, ADIO_IN
//             towards the core; ADIO_OUT, M_DATA_VLD, M_SRC_EN, M_DATA,
//             M_ADDR_N, TIME_OUT, STOPQ_N from the core.
interface pci_dma_master_if #(
  parameter int LEN_W = 12
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [31:0]      CMD_ADDR;
  logic [LEN_W-1:0] CMD_LEN;
  logic             CMD_WRITE;
  logic [31:0]      WR_DATA;
  logic             WR_VALID;
  logic             WR_READY;
  logic [31:0]      RD_DATA;
  logic             RD_VALID;
  logic             BUSY;
  logic             DONE;
  logic             ERROR;
  logic             REQUEST;
  logic             REQUESTHOLD;
  logic [3:0]       M_CBE;
  logic             M_WRDN;
  logic             COMPLETE;
  logic             M_READY;
  logic [31:0]      ADIO_IN;
  logic [31:0]      ADIO_OUT;
  logic             M_DATA_VLD;
  logic             M_SRC_EN;
  logic             M_DATA;
  logic             M_ADDR_N;
  logic             TIME_OUT;
  logic             STOPQ_N;

  modport master (
    input  CMD_VALID, CMD_ADDR, CMD_LEN, CMD_WRITE, WR_DATA, WR_VALID,
           ADIO_OUT, M_DATA_VLD, M_SRC_EN, M_DATA, M_ADDR_N, TIME_OUT, STOPQ_N,
    output CMD_READY, WR_READY, RD_DATA, RD_VALID, BUSY, DONE, ERROR,
           REQUEST, REQUESTHOLD, M_CBE, M_WRDN, COMPLETE, M_READY, ADIO_IN
  );

  modport slave (
    output CMD_VALID, CMD_ADDR, CMD_LEN, CMD_WRITE, WR_DATA, WR_VALID,
           ADIO_OUT, M_DATA_VLD, M_SRC_EN, M_DATA, M_ADDR_N, TIME_OUT, STOPQ_N,
    input  CMD_READY, WR_READY, RD_DATA, RD_VALID, BUSY, DONE, ERROR,
           REQUEST, REQUESTHOLD, M_CBE, M_WRDN, COMPLETE, M_READY, ADIO_IN
  );
endinterface

// File: rtl/pci_dma_master.sv
// PCI DMA initiator engine for one PCI function core.
// Converts one command (dword address, dword length, direction) into one or
// more PCI memory bursts of at most MAX_BURST dwords. Write data is held in a
// replay buffer until the target commits it, so a disconnected or timed-out
// burst restarts at the first uncommitted dword.
// Ports:
//   CLK   : PCI clock
//   RST_N : asynchronous active-low reset
//   bus   : pci_dma_master_if.master (user command/stream side plus the
//           core's master handshake)
module pci_dma_master #(
  parameter int LEN_W     = 12,
  parameter int BUF_AW    = 4,
  parameter int MAX_BURST = 16,
  parameter int MAX_RETRY = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  pci_dma_master_if.master bus
);
  localparam int PTR_W   = BUF_AW + 1;
  localparam int DEPTH   = 1 << BUF_AW;
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_ADDR,
    ST_DATA,
    ST_END,
    ST_FIN
  } state_t;

  state_t state, state_nxt;

  // Latched command
  logic [29:0]      base_dw;
  logic [LEN_W-1:0] len_q;
  logic             dir_q;

  // Progress tracking
  logic [LEN_W-1:0]   committed;
  logic [LEN_W-1:0]   fetched;
  logic [LEN_W-1:0]   burst_left;
  logic [RETRY_W-1:0] retry_cnt;
  logic               progress;
  logic               data_seen;
  logic               error_q;

  // Replay buffer; pointers carry one extra bit to tell full from empty
  logic [31:0]      wbuf [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] src_ptr;
  logic [PTR_W-1:0] commit_ptr;

  // Read return stage
  logic [31:0] rd_data_p1;
  logic        vld_p1;

  // Combinational core-side outputs
  logic        request;
  logic [3:0]  cbe;
  logic        wrdn;
  logic        complete;
  logic        m_ready;
  logic [31:0] adio_in;
  logic        done;

  function automatic logic [LEN_W-1:0] burst_size(input logic [LEN_W-1:0] remaining);
    if (remaining > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
    return remaining;
  endfunction

  logic               accept;
  logic               addr_phase;
  logic               commit;
  logic               src_adv;
  logic               buf_full;
  logic               wr_ready;
  logic               wr_take;
  logic               all_committed;
  logic [RETRY_W-1:0] retry_next;
  logic               retry_over;

  assign accept        = (state == ST_IDLE) && bus.CMD_VALID;
  assign addr_phase    = (state == ST_WAIT_ADDR) && !bus.M_ADDR_N;
  assign commit        = (state == ST_DATA) && bus.M_DATA_VLD;
  // Source pointer runs ahead of commits; the core may prefetch dwords that
  // the target never accepts, which is why END rewinds it.
  assign src_adv       = (state == ST_DATA) && dir_q && bus.M_SRC_EN;
  assign buf_full      = (wr_ptr[BUF_AW] != commit_ptr[BUF_AW]) &&
                         (wr_ptr[BUF_AW-1:0] == commit_ptr[BUF_AW-1:0]);
  assign wr_ready      = (state != ST_IDLE) && dir_q && (fetched != len_q) && !buf_full;
  assign wr_take       = wr_ready && bus.WR_VALID;
  assign all_committed = (committed == len_q);
  assign retry_next    = retry_cnt + 1'b1;
  assign retry_over    = (retry_next > RETRY_W'(MAX_RETRY));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and core-side outputs
  always_comb begin
    state_nxt = state;
    request   = 1'b0;
    cbe       = 4'b0000;
    wrdn      = 1'b0;
    complete  = 1'b0;
    m_ready   = 1'b0;
    adio_in   = 32'h0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.CMD_VALID) state_nxt = (bus.CMD_LEN == '0) ? ST_FIN : ST_REQ;
      end
      ST_REQ: begin
        request   = 1'b1;
        state_nxt = ST_WAIT_ADDR;
      end
      ST_WAIT_ADDR: begin
        // Resume address: base plus every dword already committed
        adio_in = {base_dw + 30'(committed), 2'b00};
        cbe     = dir_q ? 4'b0111 : 4'b0110;
        wrdn    = dir_q;
        if (!bus.M_ADDR_N) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        wrdn     = dir_q;
        adio_in  = dir_q ? wbuf[src_ptr[BUF_AW-1:0]] : 32'h0;
        m_ready  = dir_q ? (src_ptr != wr_ptr) : 1'b1;
        complete = (burst_left <= LEN_W'(1));
        // M_DATA can still be low on the first DATA cycle, so wait for it
        // to have been seen high before treating a low level as the end.
        if (data_seen && !bus.M_DATA) state_nxt = ST_END;
      end
      ST_END: begin
        if (all_committed)               state_nxt = ST_FIN;
        else if (!progress && retry_over) state_nxt = ST_FIN;
        else                              state_nxt = ST_REQ;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture (data only, no reset needed)
  always_ff @(posedge CLK) begin
    if (accept) begin
      base_dw <= bus.CMD_ADDR[31:2];
      len_q   <= bus.CMD_LEN;
      dir_q   <= bus.CMD_WRITE;
    end
  end

  // Replay buffer storage
  always_ff @(posedge CLK) begin
    if (wr_take) wbuf[wr_ptr[BUF_AW-1:0]] <= bus.WR_DATA;
  end

  // Pointers, counters, status and read return stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      committed  <= '0;
      fetched    <= '0;
      burst_left <= '0;
      retry_cnt  <= '0;
      progress   <= 1'b0;
      data_seen  <= 1'b0;
      error_q    <= 1'b0;
      wr_ptr     <= '0;
      src_ptr    <= '0;
      commit_ptr <= '0;
      rd_data_p1 <= 32'h0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;

      if (accept) begin
        committed  <= '0;
        fetched    <= '0;
        retry_cnt  <= '0;
        error_q    <= 1'b0;
        wr_ptr     <= '0;
        src_ptr    <= '0;
        commit_ptr <= '0;
      end

      if (wr_take) begin
        wr_ptr  <= wr_ptr + 1'b1;
        fetched <= fetched + 1'b1;
      end

      if (addr_phase) begin
        burst_left <= burst_size(len_q - committed);
        progress   <= 1'b0;
        data_seen  <= 1'b0;
      end

      if ((state == ST_DATA) && bus.M_DATA) data_seen <= 1'b1;

      if (src_adv) src_ptr <= src_ptr + 1'b1;

      if (commit) begin
        committed <= committed + 1'b1;
        progress  <= 1'b1;
        if (burst_left != '0) burst_left <= burst_left - 1'b1;
        if (dir_q) begin
          commit_ptr <= commit_ptr + 1'b1;
        end else begin
          rd_data_p1 <= bus.ADIO_OUT;
          vld_p1     <= 1'b1;
        end
      end

      // Attempt ended short: rewind to the first uncommitted dword and
      // account for zero-progress attempts.
      if ((state == ST_END) && !all_committed) begin
        src_ptr <= commit_ptr;
        if (progress) begin
          retry_cnt <= '0;
        end else begin
          retry_cnt <= retry_next;
          if (retry_over) error_q <= 1'b1;
        end
      end
    end
  end

  // The termination cause itself does not matter: any short attempt is
  // handled identically in END.
  logic unused_inputs;
  assign unused_inputs = ^{bus.TIME_OUT, bus.STOPQ_N, bus.CMD_ADDR[1:0]};

  assign bus.CMD_READY   = (state == ST_IDLE);
  assign bus.BUSY        = (state != ST_IDLE);
  assign bus.WR_READY    = wr_ready;
  assign bus.RD_DATA     = rd_data_p1;
  assign bus.RD_VALID    = vld_p1;
  assign bus.DONE        = done;
  assign bus.ERROR       = error_q;
  assign bus.REQUEST     = request;
  assign bus.REQUESTHOLD = 1'b0;
  assign bus.M_CBE       = cbe;
  assign bus.M_WRDN      = wrdn;
  assign bus.COMPLETE    = complete;
  assign bus.M_READY     = m_ready;
  assign bus.ADIO_IN     = adio_in;
endmodule
